// File: rtl/compare_event_tracker_if.sv
// Comparator flag bundle feeding compare_event_tracker.
// One valid strobe qualifies the eq/gt/lt flags.
interface compare_event_tracker_if;
   logic in_valid;
   logic eq;
   logic gt;
   logic lt;

   modport master (output in_valid, eq, gt, lt);
   modport slave  (input  in_valid, eq, gt, lt);
endinterface

// File: rtl/compare_event_tracker.sv
// Counts comparator results, tracks runs of identical results and
// raises an alarm on long gt/lt runs; non-one-hot flags are errors.
module compare_event_tracker #(
   parameter int CNT_W     = 8,
   parameter int STREAK_TH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   compare_event_tracker_if.slave  smp,
   output logic [CNT_W-1:0]        eq_cnt,
   output logic [CNT_W-1:0]        gt_cnt,
   output logic [CNT_W-1:0]        lt_cnt,
   output logic [CNT_W-1:0]        err_cnt,
   output logic [3:0]              streak_len,
   output logic [1:0]              state,
   output logic                    alarm,
   output logic                    alarm_pulse,
   output logic                    err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN_EQ = 2'd1,
      RUN_GT = 2'd2,
      RUN_LT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [3:0]       TH      = 4'(STREAK_TH);

   state_t            st_q, st_d;
   state_t            kind;
   logic [CNT_W-1:0]  eq_q, eq_d;
   logic [CNT_W-1:0]  gt_q, gt_d;
   logic [CNT_W-1:0]  lt_q, lt_d;
   logic [CNT_W-1:0]  ec_q, ec_d;
   logic [3:0]        sl_q, sl_d;
   logic              al_q, al_d;
   logic              pu_q, pu_d;
   logic              er_q, er_d;
   logic              legal;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // xor is high for one or three set flags; drop the all-set case
   assign legal = (smp.eq ^ smp.gt ^ smp.lt) &
                  ~(smp.eq & smp.gt & smp.lt);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         st_q <= IDLE;
         eq_q <= '0;
         gt_q <= '0;
         lt_q <= '0;
         ec_q <= '0;
         sl_q <= '0;
         al_q <= 1'b0;
         pu_q <= 1'b0;
         er_q <= 1'b0;
      end else begin
         st_q <= st_d;
         eq_q <= eq_d;
         gt_q <= gt_d;
         lt_q <= lt_d;
         ec_q <= ec_d;
         sl_q <= sl_d;
         al_q <= al_d;
         pu_q <= pu_d;
         er_q <= er_d;
      end
   end

   always_comb begin
      st_d = st_q;
      eq_d = eq_q;
      gt_d = gt_q;
      lt_d = lt_q;
      ec_d = ec_q;
      sl_d = sl_q;
      er_d = er_q;
      kind = IDLE;
      if (smp.in_valid) begin
         if (legal) begin
            unique case (1'b1)
               smp.eq: begin
                  kind = RUN_EQ;
                  eq_d = sat_inc(eq_q);
               end
               smp.gt: begin
                  kind = RUN_GT;
                  gt_d = sat_inc(gt_q);
               end
               smp.lt: begin
                  kind = RUN_LT;
                  lt_d = sat_inc(lt_q);
               end
               default: kind = IDLE;
            endcase
            if (st_q == kind) begin
               sl_d = (sl_q == 4'hF) ? sl_q : sl_q + 4'd1;
            end else begin
               st_d = kind;
               sl_d = 4'd1;
            end
         end else begin
            ec_d = sat_inc(ec_q);
            er_d = 1'b1;
         end
      end
      // idle and illegal cycles leave st/sl alone, so alarm holds
      al_d = ((st_d == RUN_GT) || (st_d == RUN_LT)) &&
             (sl_d >= TH);
      pu_d = al_d & ~al_q;
   end

   assign eq_cnt      = eq_q;
   assign gt_cnt      = gt_q;
   assign lt_cnt      = lt_q;
   assign err_cnt     = ec_q;
   assign streak_len  = sl_q;
   assign state       = st_q;
   assign alarm       = al_q;
   assign alarm_pulse = pu_q;
   assign err         = er_q;

endmodule
